// File: rtl/soc_imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Imported by the arbiter top and its round-robin sub-block.
package soc_imem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LOAD  = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/soc_imem_arbiter_if.sv
// Bus bundle for the imem arbiter: fetch port, loader port,
// memory side and zero-fill control.
interface soc_imem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   s0_address;
  logic                s0_read;
  logic                s0_waitrequest;
  logic                s0_readdatavalid;

  logic [ADDR_W-1:0]   s1_address;
  logic                s1_read;
  logic                s1_write;
  logic [DATA_W/8-1:0] s1_byteenable;
  logic [DATA_W-1:0]   s1_writedata;
  logic                s1_waitrequest;
  logic                s1_readdatavalid;

  logic [DATA_W-1:0]   readdata;

  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;

  logic                clear_start;
  logic                clear_busy;

  modport slave (
    input  s0_address, s0_read,
    output s0_waitrequest, s0_readdatavalid,
    input  s1_address, s1_read, s1_write,
    input  s1_byteenable, s1_writedata,
    output s1_waitrequest, s1_readdatavalid,
    output readdata,
    output mem_address, mem_chipselect, mem_write,
    output mem_byteenable, mem_writedata,
    input  mem_readdata,
    input  clear_start,
    output clear_busy
  );

  modport master (
    output s0_address, s0_read,
    input  s0_waitrequest, s0_readdatavalid,
    output s1_address, s1_read, s1_write,
    output s1_byteenable, s1_writedata,
    input  s1_waitrequest, s1_readdatavalid,
    input  readdata,
    input  mem_address, mem_chipselect, mem_write,
    input  mem_byteenable, mem_writedata,
    output mem_readdata,
    output clear_start,
    input  clear_busy
  );

endinterface

// File: rtl/soc_imem_rr_arb.sv
// Two-way round-robin grant; the port not granted last wins
// a tie. last_q resets to the loader so fetch wins first.
module soc_imem_rr_arb
  import soc_imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || last_q == PORT_LOAD))
        gnt_o[0] = 1'b1;
      else if (req_i[1])
        gnt_o[1] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_q <= PORT_LOAD;
    else if (gnt_o[0])
      last_q <= PORT_FETCH;
    else if (gnt_o[1])
      last_q <= PORT_LOAD;
  end

endmodule

// File: rtl/soc_imem_arbiter.sv
// Shares one single-port instruction memory between fetch and
// loader ports, with a full-memory zero-fill mode.
module soc_imem_arbiter
  import soc_imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic reset,
  soc_imem_arbiter_if.slave bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic [1:0]        rdv_q;
  logic [1:0]        rdv_d;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              clr_act;

  assign req[0]  = bus.s0_read;
  assign req[1]  = bus.s1_read | bus.s1_write;
  // Reset suppresses every memory access, so an aborted fill
  // never touches the address it was about to write.
  assign arb_en  = (state_q == IDLE) & ~reset;
  assign clr_act = (state_q == CLEAR) & ~reset;

  soc_imem_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (arb_en),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign bus.s0_waitrequest = req[0] & ~gnt[0];
  assign bus.s1_waitrequest = req[1] & ~gnt[1];

  always_comb begin
    bus.mem_chipselect = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_address    = '0;
    bus.mem_byteenable = {(DATA_W/8){1'b1}};
    bus.mem_writedata  = {DATA_W{1'b0}};
    unique case (1'b1)
      clr_act: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_write      = 1'b1;
        bus.mem_address    = cnt_q;
      end
      gnt[0]: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = bus.s0_address;
      end
      gnt[1]: begin
        bus.mem_chipselect = 1'b1;
        bus.mem_address    = bus.s1_address;
        if (bus.s1_write) begin
          bus.mem_write      = 1'b1;
          bus.mem_byteenable = bus.s1_byteenable;
          bus.mem_writedata  = bus.s1_writedata;
        end
      end
      default: ;
    endcase
  end

  assign rdv_d[0] = gnt[0];
  assign rdv_d[1] = gnt[1] & ~bus.s1_write;

  always_ff @(posedge clk) begin
    if (reset)
      rdv_q <= 2'b00;
    else
      rdv_q <= rdv_d;
  end

  assign bus.s0_readdatavalid = rdv_q[0];
  assign bus.s1_readdatavalid = rdv_q[1];
  assign bus.readdata         = bus.mem_readdata;
  assign bus.clear_busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_imem_arbiter.sv
// Directed bench for soc_imem_arbiter with a 1-cycle-latency
// byte-lane memory model behind the mem_* port.
module tb_soc_imem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_mem = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  soc_imem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  soc_imem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_val(int i);
    return {8'hC0, i[7:0], 8'h5A, i[7:0]};
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= init_val(i);
    end else if (bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b])
            mem[bus.mem_address][8*b+:8] <=
              bus.mem_writedata[8*b+:8];
      end else begin
        bus.mem_readdata <= mem[bus.mem_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s0_address    = '0;
    bus.s0_read       = 1'b0;
    bus.s1_address    = '0;
    bus.s1_read       = 1'b0;
    bus.s1_write      = 1'b0;
    bus.s1_byteenable = '0;
    bus.s1_writedata  = '0;
    bus.clear_start   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    init_mem = 1'b1;
    tick();
    init_mem = 1'b0;
    tick();
    n_cmp++;
    if (bus.clear_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy: got %b want 0", bus.clear_busy);
    end
    n_cmp++;
    if (bus.s0_readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rdv0: got %b want 0",
               bus.s0_readdatavalid);
    end
    n_cmp++;
    if (bus.s1_readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_rdv1: got %b want 0",
               bus.s1_readdatavalid);
    end
    n_cmp++;
    if (bus.mem_chipselect !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_cs: got %b want 0", bus.mem_chipselect);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    bus.s0_read    = 1'b1;
    bus.s0_address = 8'h10;
    #1;
    n_cmp++;
    if (bus.s0_waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL sr_wait: got %b want 0", bus.s0_waitrequest);
    end
    n_cmp++;
    if (bus.mem_address !== 8'h10) begin
      n_bad++;
      $display("FAIL sr_addr: got %h want 10", bus.mem_address);
    end
    n_cmp++;
    if ({bus.mem_chipselect, bus.mem_write,
         bus.mem_byteenable} !== 6'b10_1111) begin
      n_bad++;
      $display("FAIL sr_ctl: got %b%b%b want 101111",
               bus.mem_chipselect, bus.mem_write,
               bus.mem_byteenable);
    end
    tick();
    bus.s0_read = 1'b0;
    #1;
    n_cmp++;
    if ({bus.s0_readdatavalid, bus.s1_readdatavalid}
        !== 2'b10) begin
      n_bad++;
      $display("FAIL sr_rdv: got %b%b want 10",
               bus.s0_readdatavalid, bus.s1_readdatavalid);
    end
    n_cmp++;
    if (bus.readdata !== init_val(8'h10)) begin
      n_bad++;
      $display("FAIL sr_data: got %h want %h",
               bus.readdata, init_val(8'h10));
    end
  endtask

  task automatic test_contention();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.s0_read       = 1'b1;
    bus.s0_address    = 8'h21;
    bus.s1_write      = 1'b1;
    bus.s1_address    = 8'h20;
    bus.s1_writedata  = 32'h1234_5678;
    bus.s1_byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({bus.s0_waitrequest, bus.s1_waitrequest,
           bus.mem_write} !== ((k % 2 == 0) ? 3'b010 : 3'b101))
      begin
        n_bad++;
        $display("FAIL ct_grant%0d: got w0=%b w1=%b we=%b",
                 k, bus.s0_waitrequest, bus.s1_waitrequest,
                 bus.mem_write);
      end
      n_cmp++;
      if (bus.s0_readdatavalid !== (k % 2 == 1)) begin
        n_bad++;
        $display("FAIL ct_rdv%0d: got %b want %b", k,
                 bus.s0_readdatavalid, (k % 2 == 1));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_byteenable();
    logic [31:0] exp;
    exp = init_val(8'h05);
    exp[15:0] = 16'hBEEF;
    tick();
    bus.s1_write      = 1'b1;
    bus.s1_address    = 8'h05;
    bus.s1_writedata  = 32'hDEAD_BEEF;
    bus.s1_byteenable = 4'b0011;
    #1;
    n_cmp++;
    if (bus.mem_byteenable !== 4'b0011) begin
      n_bad++;
      $display("FAIL be_lanes: got %b want 0011",
               bus.mem_byteenable);
    end
    tick();
    idle_inputs();
    bus.s0_read    = 1'b1;
    bus.s0_address = 8'h05;
    #1;
    n_cmp++;
    if (bus.s1_readdatavalid !== 1'b0) begin
      n_bad++;
      $display("FAIL be_wr_rdv: got %b want 0",
               bus.s1_readdatavalid);
    end
    tick();
    bus.s0_read = 1'b0;
    #1;
    n_cmp++;
    if (bus.readdata !== exp) begin
      n_bad++;
      $display("FAIL be_data: got %h want %h", bus.readdata, exp);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.s0_read    = 1'b1;
      bus.s0_address = 8'h30 + k[7:0];
      #1;
      n_cmp++;
      if (bus.s0_waitrequest !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_wait%0d: got %b want 0", k,
                 bus.s0_waitrequest);
      end
      if (k > 0) begin
        n_cmp++;
        if (!bus.s0_readdatavalid ||
            bus.readdata !== init_val(8'h30 + k - 1)) begin
          n_bad++;
          $display("FAIL b2b_data%0d: got %b/%h want 1/%h", k,
                   bus.s0_readdatavalid, bus.readdata,
                   init_val(8'h30 + k - 1));
        end
      end
      tick();
    end
    idle_inputs();
    bus.s1_read    = 1'b1;
    bus.s1_address = 8'h44;
    #1;
    n_cmp++;
    if (!bus.s0_readdatavalid ||
        bus.readdata !== init_val(8'h33)) begin
      n_bad++;
      $display("FAIL b2b_last: got %b/%h want 1/%h",
               bus.s0_readdatavalid, bus.readdata,
               init_val(8'h33));
    end
    tick();
    bus.s1_read = 1'b0;
    #1;
    n_cmp++;
    if ({bus.s0_readdatavalid, bus.s1_readdatavalid} !== 2'b01 ||
        bus.readdata !== init_val(8'h44)) begin
      n_bad++;
      $display("FAIL s1_read: got %b%b/%h want 01/%h",
               bus.s0_readdatavalid, bus.s1_readdatavalid,
               bus.readdata, init_val(8'h44));
    end
  endtask

  task automatic test_clear();
    int n;
    int bad;
    tick();
    bus.s0_read     = 1'b1;
    bus.s0_address  = 8'h40;
    bus.clear_start = 1'b1;
    #1;
    n_cmp++;
    if (bus.s0_waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_lastgnt: got %b want 0",
               bus.s0_waitrequest);
    end
    tick();
    idle_inputs();
    bus.s1_read    = 1'b1;
    bus.s1_address = 8'h00;
    #1;
    n_cmp++;
    if (!bus.clear_busy || !bus.s0_readdatavalid ||
        bus.readdata !== init_val(8'h40)) begin
      n_bad++;
      $display("FAIL clr_first: busy=%b rdv=%b d=%h want 1/1/%h",
               bus.clear_busy, bus.s0_readdatavalid,
               bus.readdata, init_val(8'h40));
    end
    n = 0;
    bad = 0;
    while (bus.clear_busy && n < 300) begin
      if (bus.mem_address !== n[7:0] || bus.mem_write !== 1'b1 ||
          bus.mem_writedata !== 32'h0 ||
          bus.s1_waitrequest !== 1'b1)
        bad++;
      n++;
      tick();
    end
    n_cmp++;
    if (n !== 256) begin
      n_bad++;
      $display("FAIL clr_len: got %0d want 256", n);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL clr_cycles: got %0d bad want 0", bad);
    end
    n_cmp++;
    if (bus.s1_waitrequest !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_resume: got %b want 0",
               bus.s1_waitrequest);
    end
    tick();
    bus.s1_read    = 1'b0;
    bus.s0_read    = 1'b1;
    bus.s0_address = 8'hFF;
    #1;
    n_cmp++;
    if (!bus.s1_readdatavalid || bus.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL clr_rd00: got %b/%h want 1/0",
               bus.s1_readdatavalid, bus.readdata);
    end
    tick();
    bus.s0_read = 1'b0;
    #1;
    n_cmp++;
    if (!bus.s0_readdatavalid || bus.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL clr_rdff: got %b/%h want 1/0",
               bus.s0_readdatavalid, bus.readdata);
    end
  endtask

  task automatic test_clear_reset();
    tick();
    bus.s1_write      = 1'b1;
    bus.s1_byteenable = 4'hF;
    bus.s1_address    = 8'h63;
    bus.s1_writedata  = 32'h1111_1111;
    tick();
    bus.s1_address    = 8'h64;
    bus.s1_writedata  = 32'h2222_2222;
    tick();
    idle_inputs();
    bus.clear_start = 1'b1;
    tick();
    bus.clear_start = 1'b0;
    repeat (100) tick();
    n_cmp++;
    if (bus.mem_address !== 8'h64 || !bus.clear_busy) begin
      n_bad++;
      $display("FAIL cr_at100: got %h/%b want 64/1",
               bus.mem_address, bus.clear_busy);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_chipselect !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_cs: got %b want 0", bus.mem_chipselect);
    end
    tick();
    reset = 1'b0;
    n_cmp++;
    if (bus.clear_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cr_busy: got %b want 0", bus.clear_busy);
    end
    bus.s0_read    = 1'b1;
    bus.s0_address = 8'h63;
    tick();
    bus.s0_address = 8'h64;
    #1;
    n_cmp++;
    if (bus.readdata !== 32'h0) begin
      n_bad++;
      $display("FAIL cr_63: got %h want 0", bus.readdata);
    end
    tick();
    bus.s0_read = 1'b0;
    #1;
    n_cmp++;
    if (bus.readdata !== 32'h2222_2222) begin
      n_bad++;
      $display("FAIL cr_64: got %h want 22222222", bus.readdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_byteenable();
    test_back_to_back();
    test_clear();
    test_clear_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
